// File: rtl/clock_pkg.sv
// clock_pkg
//   Shared constants for the six-digit 12-hour clock: mode codes sent to the
//   digit modules, edit-field codes, digit identities, BCD limits, the
//   sequencer FSM encoding and the BCD increment helpers.
package clock_pkg;

  // Mode codes driven on the shared `state` bus
  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_SET   = 4'd1;
  localparam logic [3:0] ST_START = 4'd3;

  // Field currently being edited in Set mode
  localparam logic [1:0] F_SEC  = 2'd0;
  localparam logic [1:0] F_MIN  = 2'd1;
  localparam logic [1:0] F_HOUR = 2'd2;

  // Digit identities, least significant first
  localparam int DIGIT_SEC_UNITS  = 1;
  localparam int DIGIT_SEC_TENS   = 2;
  localparam int DIGIT_MIN_UNITS  = 3;
  localparam int DIGIT_MIN_TENS   = 4;
  localparam int DIGIT_HOUR_UNITS = 5;
  localparam int DIGIT_HOUR_TENS  = 6;

  // BCD limits and the power-on / clear preset 12:00:00
  localparam logic [7:0]  BCD_MAX_SEXA = 8'h59;
  localparam logic [7:0]  BCD_MAX_HOUR = 8'h12;
  localparam logic [7:0]  BCD_MIN_HOUR = 8'h01;
  localparam logic [23:0] SET_DEFAULT  = 24'h120000;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_SET   = 2'd1,
    S_RUN   = 2'd2
  } fsm_t;

  // Mode code the digits see for each sequencer state
  function automatic logic [3:0] mode_code(input fsm_t s);
    logic [3:0] r;
    case (s)
      S_SET:   r = ST_SET;
      S_RUN:   r = ST_START;
      default: r = ST_RESET;
    endcase
    return r;
  endfunction

  // 00..59 with wrap; BCD ordering matches numeric ordering for valid digits
  function automatic logic [7:0] bcd_inc_sexa(input logic [7:0] v);
    logic [7:0] r;
    if (v >= BCD_MAX_SEXA)   r = 8'h00;
    else if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // 01..12 with wrap 12 -> 01
  function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
    logic [7:0] r;
    if (v >= BCD_MAX_HOUR)   r = BCD_MIN_HOUR;
    else if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/button_edge.sv
// button_edge
//   Synchronises one asynchronous active-high push-button into clk and emits
//   a single-cycle pulse on each rising edge of the synchronised level.
//   Ports:
//     clk     in   system clock
//     reset_n in   asynchronous active-low reset
//     btn     in   raw button level
//     press   out  one-cycle press pulse (combinational from flops)
//   SYNC_STAGES must be at least 2.
module button_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // A held button keeps prev high, so only the first synchronised cycle pulses
  assign press = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/clock_mode_controller.sv
// clock_mode_controller
//   Sequencer for the six-digit 12-hour clock. Turns the mode/next/inc/clear
//   buttons into the shared mode code, runs the one-second divider and holds
//   the BCD preset the digits load in Set mode.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     btn_mode/next/inc/clear  raw asynchronous push-buttons
//     state      mode code to digits (0 reset, 1 set, 3 start)
//     rCount     second divider value, counts only in run
//     canIMove   high exactly while running
//     tick       one-cycle pulse coinciding with rCount == TICK_MAX
//     set_value  BCD preset {HH,MM,SS}
//     field_sel  field being edited (0 sec, 1 min, 2 hour)
//   Valid/ready: none; buttons are level inputs and all outputs are
//   registered levels/pulses with no back-pressure.
module clock_mode_controller
  import clock_pkg::*;
#(
  parameter int TICK_MAX    = 49999999,
  parameter int CNT_W       = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_mode,
  input  logic             btn_next,
  input  logic             btn_inc,
  input  logic             btn_clear,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] rCount,
  output logic             canIMove,
  output logic             tick,
  output logic [23:0]      set_value,
  output logic [1:0]       field_sel
);

  localparam logic [CNT_W-1:0] TICK_TERM = CNT_W'(TICK_MAX);

  logic p_mode, p_next, p_inc, p_clear;

  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode (
    .clk(clk), .reset_n(reset_n), .btn(btn_mode), .press(p_mode));
  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_next (
    .clk(clk), .reset_n(reset_n), .btn(btn_next), .press(p_next));
  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc (
    .clk(clk), .reset_n(reset_n), .btn(btn_inc), .press(p_inc));
  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk(clk), .reset_n(reset_n), .btn(btn_clear), .press(p_clear));

  // Only the highest-priority pulse of a cycle acts: clear > mode > next > inc
  logic do_clear, do_mode, do_next, do_inc;
  assign do_clear = p_clear;
  assign do_mode  = p_mode & ~p_clear;
  assign do_next  = p_next & ~p_clear & ~p_mode;
  assign do_inc   = p_inc  & ~p_clear & ~p_mode & ~p_next;

  fsm_t             fsm, fsm_next;
  logic [23:0]      set_next;
  logic [1:0]       field_next;
  logic [CNT_W-1:0] rcount_next;

  always_comb begin
    fsm_next    = fsm;
    set_next    = set_value;
    field_next  = field_sel;
    rcount_next = '0;

    if (do_clear) begin
      fsm_next   = S_RESET;
      set_next   = SET_DEFAULT;
      field_next = F_SEC;
    end else if (do_mode) begin
      case (fsm)
        S_RESET: fsm_next = S_SET;
        S_SET:   fsm_next = S_RUN;
        // Run always returns through reset; the digits need that pass
        default: fsm_next = S_RESET;
      endcase
    end else if (fsm == S_SET) begin
      if (do_next) begin
        field_next = (field_sel == F_MIN) ? F_HOUR :
                     (field_sel == F_SEC) ? F_MIN  : F_SEC;
      end else if (do_inc) begin
        case (field_sel)
          F_SEC:   set_next[7:0]   = bcd_inc_sexa(set_value[7:0]);
          F_MIN:   set_next[15:8]  = bcd_inc_sexa(set_value[15:8]);
          F_HOUR:  set_next[23:16] = bcd_inc_hour(set_value[23:16]);
          default: set_next        = set_value;
        endcase
      end
    end

    // Count only while staying in run, so entry starts at 0 and leaving
    // clears the divider on the same edge the mode code changes
    if (fsm == S_RUN && fsm_next == S_RUN) begin
      rcount_next = (rCount == TICK_TERM) ? '0 : rCount + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm       <= S_RESET;
      state     <= ST_RESET;
      canIMove  <= 1'b0;
      rCount    <= '0;
      tick      <= 1'b0;
      set_value <= SET_DEFAULT;
      field_sel <= F_SEC;
    end else begin
      fsm       <= fsm_next;
      state     <= mode_code(fsm_next);
      canIMove  <= (fsm_next == S_RUN);
      rCount    <= rcount_next;
      // Registered from next-cycle values so tick lines up with rCount
      tick      <= (fsm_next == S_RUN) && (rcount_next == TICK_TERM);
      set_value <= set_next;
      field_sel <= field_next;
    end
  end

endmodule

// File: tb/tb_clock_mode_controller.sv
// tb_clock_mode_controller
//   Directed bench for clock_mode_controller with TICK_MAX=9, SYNC_STAGES=2.
//   A time-value model (integers for mode, h/m/s, field, run age) is stepped
//   from the raw button history and compared every cycle; literal checks pin
//   the model at key points.
module tb_clock_mode_controller;

  localparam int TICK_MAX = 9;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             btn_mode = 1'b0;
  logic             btn_next = 1'b0;
  logic             btn_inc = 1'b0;
  logic             btn_clear = 1'b0;
  logic [3:0]       state;
  logic [CNT_W-1:0] rCount;
  logic             canIMove;
  logic             tick;
  logic [23:0]      set_value;
  logic [1:0]       field_sel;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  clock_mode_controller #(
    .TICK_MAX(TICK_MAX), .CNT_W(CNT_W), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_mode(btn_mode), .btn_next(btn_next),
    .btn_inc(btn_inc), .btn_clear(btn_clear),
    .state(state), .rCount(rCount), .canIMove(canIMove), .tick(tick),
    .set_value(set_value), .field_sel(field_sel)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // m_mode is the mode code itself (0/1/3); m_age counts edges since entering run
  int       m_mode, m_hh, m_mm, m_ss, m_field, m_age;
  logic [2:0] hist [4];  // per button: [0]=sample at n-1, [1]=n-2, [2]=n-3

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hh = 12; m_mm = 0; m_ss = 0; m_field = 0; m_age = 0;
    for (int b = 0; b < 4; b++) hist[b] = 3'b000;
  endtask

  task automatic model_step();
    logic [3:0] now_s;
    logic [3:0] pr;
    int old_mode;
    now_s = {btn_clear, btn_inc, btn_next, btn_mode};
    // A press acts on the third edge after the level is first sampled high
    for (int b = 0; b < 4; b++) begin
      pr[b]   = hist[b][1] & ~hist[b][2];
      hist[b] = {hist[b][1:0], now_s[b]};
    end
    old_mode = m_mode;
    if (pr[3]) begin
      m_mode = 0; m_hh = 12; m_mm = 0; m_ss = 0; m_field = 0;
    end else if (pr[0]) begin
      m_mode = (m_mode == 0) ? 1 : (m_mode == 1) ? 3 : 0;
    end else if (m_mode == 1) begin
      if (pr[1]) m_field = (m_field + 1) % 3;
      else if (pr[2]) begin
        case (m_field)
          0:       m_ss = (m_ss + 1) % 60;
          1:       m_mm = (m_mm + 1) % 60;
          default: m_hh = (m_hh % 12) + 1;
        endcase
      end
    end
    m_age = (old_mode == 3 && m_mode == 3) ? m_age + 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("cyc_state", 32'(state), 32'(m_mode));
    check("cyc_rcount", 32'(rCount), 32'(m_age % (TICK_MAX + 1)));
    check("cyc_move", 32'(canIMove), 32'(m_mode == 3));
    check("cyc_tick", 32'(tick),
          32'(m_mode == 3 && (m_age % (TICK_MAX + 1)) == TICK_MAX));
    check("cyc_set", 32'(set_value),
          32'({to_bcd(m_hh), to_bcd(m_mm), to_bcd(m_ss)}));
    check("cyc_field", 32'(field_sel), 32'(m_field));
  end

  // ---------------- drivers ----------------
  // which: 0 mode, 1 next, 2 inc, 3 clear
  task automatic drive_btn(input int which, input logic v);
    case (which)
      0:       btn_mode  = v;
      1:       btn_next  = v;
      2:       btn_inc   = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    @(negedge clk);
    drive_btn(which, 1'b1);
    repeat (hold) @(negedge clk);
    drive_btn(which, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic press_pair(input int a, input int b);
    @(negedge clk);
    drive_btn(a, 1'b1);
    drive_btn(b, 1'b1);
    repeat (2) @(negedge clk);
    drive_btn(a, 1'b0);
    drive_btn(b, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  // Press mode and return #1 after the edge on which it takes effect
  task automatic mode_to_edge3();
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_rcount", 32'(rCount), 32'd0);
    check("rst_move", 32'(canIMove), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_set", 32'(set_value), 32'h120000);
    check("rst_field", 32'(field_sel), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode press latency: state changes on the third edge
    @(negedge clk);
    btn_mode = 1'b1;
    @(posedge clk); #1 check("mode_edge1", 32'(state), 32'd0);
    @(posedge clk); #1 check("mode_edge2", 32'(state), 32'd0);
    @(posedge clk); #1 check("mode_edge3", 32'(state), 32'd1);
    btn_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Seconds: 58 -> 59 -> 00 without touching minutes
    repeat (58) press(2, 2);
    check("sec_58", 32'(set_value), 32'h120058);
    press(2, 2);
    check("sec_59", 32'(set_value), 32'h120059);
    press(2, 2);
    check("sec_wrap", 32'(set_value), 32'h120000);

    // Hour field: 12 -> 01, 09 -> 10
    press(1, 2);
    press(1, 2);
    check("field_hour", 32'(field_sel), 32'd2);
    press(2, 2);
    check("hour_12_01", 32'(set_value), 32'h010000);
    repeat (8) press(2, 2);
    check("hour_09", 32'(set_value), 32'h090000);
    press(2, 2);
    check("hour_10", 32'(set_value), 32'h100000);
    repeat (3) press(2, 2);
    check("hour_wrap2", 32'(set_value), 32'h010000);

    // Enter run and watch the divider
    mode_to_edge3();
    check("run_state", 32'(state), 32'd3);
    check("run_move", 32'(canIMove), 32'd1);
    check("run_cnt0", 32'(rCount), 32'd0);
    btn_mode = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("run_cnt9", 32'(rCount), 32'd9);
    check("run_tick1", 32'(tick), 32'd1);
    @(posedge clk);
    #1 check("run_wrap", 32'(rCount), 32'd0);
    check("run_tick_lo", 32'(tick), 32'd0);
    repeat (9) @(posedge clk);
    #1 check("run_tick2", 32'(tick), 32'd1);

    // Run -> reset -> set, never straight back to run
    press(0, 2);
    check("back_state", 32'(state), 32'd0);
    check("back_rcount", 32'(rCount), 32'd0);
    check("back_move", 32'(canIMove), 32'd0);
    press(0, 2);
    check("reset_to_set", 32'(state), 32'd1);

    // Mode beats inc in the same cycle
    press_pair(0, 2);
    check("prio_state", 32'(state), 32'd3);
    check("prio_set", 32'(set_value), 32'h010000);

    // Clear beats mode
    press_pair(3, 0);
    check("clear_state", 32'(state), 32'd0);
    check("clear_set", 32'(set_value), 32'h120000);
    check("clear_field", 32'(field_sel), 32'd0);

    // Held inc increments once
    press(0, 2);
    press(2, 50);
    check("held_inc", 32'(set_value), 32'h120001);

    // Asynchronous reset mid-count
    mode_to_edge3();
    btn_mode = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("mid_cnt5", 32'(rCount), 32'd5);
    reset_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_rcount", 32'(rCount), 32'd0);
    check("async_move", 32'(canIMove), 32'd0);
    check("async_tick", 32'(tick), 32'd0);
    check("async_set", 32'(set_value), 32'h120000);
    check("async_field", 32'(field_sel), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
